wbs_sram16: RTL and testbench
=============================

Name: wbs_sram16

Overview:
- Wishbone B.4 pipelined-mode slave with a 16-bit data bus, backed by a synchronous halfword RAM.
- It is the responder end of the 16-bit load/store master bus.
- It accepts one strobe per clock with no stall, so byte, halfword, word and dword bursts run back-to-back.
- Each request is acknowledged a fixed LATENCY cycles after acceptance, in order, with read data aligned to the ack.

Parameters:
- AW, 10, halfword address bits; RAM holds 2^AW halfwords (byte address bits [AW:1] index the RAM).
- LATENCY, 1, request-to-ack delay in clocks; legal range 1..4.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- reset_ni  input  1  reset, asynchronous, active-low.
- wbsadr_i  input  64  byte address from master.
- wbsdat_i  input  16  write data.
- wbswe_i  input  1  1 = write, 0 = read.
- wbssel_i  input  2  byte lane select; bit0 = [7:0], bit1 = [15:8].
- wbsstb_i  input  1  request strobe.
- wbscyc_i  input  1  bus cycle in progress.
- wbsdat_o  output  16  read data, valid while wbsack_o = 1.
- wbsack_o  output  1  acknowledge, one pulse per accepted request.
- wbsstall_o  output  1  constant 0; the slave never stalls.
- wbserr_o  output  1  error response (see Optional Feature).

Behaviour:
- Reset (reset_ni = 0, asynchronous):
  - Ack pipeline cleared; wbsack_o = 0, wbserr_o = 0, wbsdat_o = 0.
  - RAM contents are not reset.
- Accept condition: wbscyc_i & wbsstb_i sampled high on a rising edge. Every such cycle is one request. Back-to-back accepts are legal every cycle.
- Address: idx = wbsadr_i[AW:1]. wbsadr_i[0] is ignored; lane selection comes only from wbssel_i.
- Write, on the accept edge:
  - RAM[idx][7:0] <= wbsdat_i[7:0] if wbssel_i[0].
  - RAM[idx][15:8] <= wbsdat_i[15:8] if wbssel_i[1].
  - wbssel_i = 00 writes nothing but is still acked.
- Read: on the accept edge, capture the full halfword RAM[idx] regardless of wbssel_i. The master picks the lane.
- Ordering: a read accepted the cycle after a write to the same idx returns the new data. Same-edge write-then-read is impossible because there is one request per edge.
- Ack pipeline:
  - LATENCY-stage shift register of {valid, is_write, err, data[15:0]}.
  - Stage 0 loads on accept. wbsack_o = valid of stage LATENCY-1.
  - wbsdat_o = that stage's data for reads; 0 for writes and when not acking.
  - LATENCY = 1: ack appears the cycle after the strobe edge.
- Throughput: N consecutive strobes produce N consecutive acks, delayed by LATENCY cycles.
- Abort: if wbscyc_i is low on an edge, all pipeline valid bits are cleared that edge.
  - Pending acks are discarded and no ack is driven while cyc is low.
  - Writes already committed remain committed.
- Strobe without cyc: ignored; no RAM access, no ack.
- Outstanding count never exceeds LATENCY. No overflow condition exists.
- Address wrap: bits above AW are ignored (RAM aliases) unless WBS_ERR_EN is defined.

Optional Feature:
- Macro: WBS_ERR_EN.
- Defined:
  - A request with any of wbsadr_i[63:AW+1] nonzero is out of range.
  - Its write is suppressed.
  - It travels the pipeline with err = 1 and is answered with wbserr_o = 1, wbsack_o = 0, wbsdat_o = 0 at the normal LATENCY slot.
- Not defined: wbserr_o is tied 0 and upper address bits alias.

Test Plan:
- Reset: hold reset_ni = 0 mid-burst (stage 0 valid), then release -> wbsack_o = 0 immediately and stays 0 until a new strobe is accepted.
- Halfword write/read, LATENCY = 1:
  - Stimulus: write sel = 11, adr = 0x10, dat = 0xBEEF; then read adr = 0x10.
  - Response: ack on the cycle after each strobe; read returns wbsdat_o = 0xBEEF.
- Byte lanes:
  - Stimulus: write 0x1234 @ 0x20 sel 11; write 0xAA55 @ 0x21 sel 10; write 0xCC77 @ 0x20 sel 01; read @ 0x20.
  - Response: wbsdat_o = 0xAA77.
- Dword burst, LATENCY = 3:
  - Stimulus: 4 consecutive read strobes at 0x40, 0x42, 0x44, 0x46, preloaded with 0x1111, 0x2222, 0x3333, 0x4444.
  - Response: 4 consecutive acks starting 3 cycles after the first strobe, data in that order.
- Abort, LATENCY = 3:
  - Stimulus: 2 read strobes, then wbscyc_i dropped for 1 cycle.
  - Response: no acks emitted; a following single read is acked after exactly 3 cycles.
- WBS_ERR_EN, AW = 10:
  - Stimulus: write 0x5A5A to adr 0x800, then read adr 0x000.
  - Response: the write gets wbserr_o = 1 and wbsack_o = 0; the read of 0x000 returns the prior value, unchanged.

Source files
------------

// File: rtl/wbs_sram16.sv
// rtl/wbs_sram16.sv - Wishbone B.4 pipelined 16-bit SRAM slave, fixed-latency in-order acks (optional WBS_ERR_EN)
module wbs_sram16 #(
  parameter int AW      = 10,
  parameter int LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [63:0] wbsadr_i,
  input  logic [15:0] wbsdat_i,
  input  logic        wbswe_i,
  input  logic [1:0]  wbssel_i,
  input  logic        wbsstb_i,
  input  logic        wbscyc_i,
  output logic [15:0] wbsdat_o,
  output logic        wbsack_o,
  output logic        wbsstall_o,
  output logic        wbserr_o
);

  localparam int TOP = LATENCY - 1;

  logic [15:0]        mem [2**AW];
  logic               accept;
  logic [AW-1:0]      idx;
  logic               oor;

  // ack pipeline: valid / is_write / err / data per stage
  logic [LATENCY-1:0] pv;
  logic [LATENCY-1:0] pw;
  logic [LATENCY-1:0] pe;
  logic [15:0]        pd [LATENCY];

  assign accept = wbscyc_i & wbsstb_i;
  assign idx    = wbsadr_i[AW:1];

`ifdef WBS_ERR_EN
  // any nonzero bit above the RAM window makes the request out of range
  assign oor = |wbsadr_i[63:AW+1];
  logic unused_adr;
  assign unused_adr = wbsadr_i[0];
`else
  // upper address bits alias onto the RAM; byte bit 0 never selects a lane
  assign oor = 1'b0;
  logic unused_adr;
  assign unused_adr = &{1'b0, wbsadr_i[63:AW+1], wbsadr_i[0]};
`endif

  // byte-lane RAM write on the accept edge; out-of-range writes are dropped
  always_ff @(posedge clk_i) begin
    if (accept && wbswe_i && !oor) begin
      if (wbssel_i[0]) mem[idx][7:0]  <= wbsdat_i[7:0];
      if (wbssel_i[1]) mem[idx][15:8] <= wbsdat_i[15:8];
    end
  end

  // load stage 0 on accept and shift toward the ack slot; cyc low flushes all valids
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pv <= '0;
      pw <= '0;
      pe <= '0;
      for (int i = 0; i < LATENCY; i++) pd[i] <= '0;
    end else begin
      if (!wbscyc_i) begin
        pv <= '0;
      end else begin
        pv[0] <= accept;
        for (int i = 1; i < LATENCY; i++) pv[i] <= pv[i-1];
      end
      pw[0] <= wbswe_i;
      pe[0] <= oor;
      // full halfword captured for reads; the master picks the lane
      pd[0] <= (accept && !wbswe_i && !oor) ? mem[idx] : 16'h0000;
      for (int i = 1; i < LATENCY; i++) begin
        pw[i] <= pw[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign wbsstall_o = 1'b0;
  assign wbsack_o   = wbscyc_i & pv[TOP] & ~pe[TOP];
  assign wbsdat_o   = (wbsack_o && !pw[TOP]) ? pd[TOP] : 16'h0000;

`ifdef WBS_ERR_EN
  assign wbserr_o = wbscyc_i & pv[TOP] & pe[TOP];
`else
  assign wbserr_o = 1'b0;
`endif

endmodule

// File: tb/tb_wbs_sram16.sv
// tb/tb_wbs_sram16.sv - directed self-checking bench for wbs_sram16 (LATENCY 1 and 3 instances)
module tb_wbs_sram16;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic [63:0] wbsadr_i = '0;
  logic [15:0] wbsdat_i = '0;
  logic        wbswe_i = 1'b0;
  logic [1:0]  wbssel_i = '0;
  logic        wbsstb_i = 1'b0;
  logic        wbscyc_i = 1'b0;

  logic [15:0] dat1, dat3;
  logic        ack1, ack3, stall1, stall3, err1, err3;

  // values captured at each negedge, just before new inputs are driven
  logic [15:0] s_dat1, s_dat3;
  logic        s_ack1, s_ack3, s_err1, s_err3;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  wbs_sram16 #(.AW(10), .LATENCY(1)) u_l1 (
    .clk_i(clk_i), .reset_ni(reset_ni), .wbsadr_i(wbsadr_i), .wbsdat_i(wbsdat_i),
    .wbswe_i(wbswe_i), .wbssel_i(wbssel_i), .wbsstb_i(wbsstb_i), .wbscyc_i(wbscyc_i),
    .wbsdat_o(dat1), .wbsack_o(ack1), .wbsstall_o(stall1), .wbserr_o(err1)
  );

  wbs_sram16 #(.AW(10), .LATENCY(3)) u_l3 (
    .clk_i(clk_i), .reset_ni(reset_ni), .wbsadr_i(wbsadr_i), .wbsdat_i(wbsdat_i),
    .wbswe_i(wbswe_i), .wbssel_i(wbssel_i), .wbsstb_i(wbsstb_i), .wbscyc_i(wbscyc_i),
    .wbsdat_o(dat3), .wbsack_o(ack3), .wbsstall_o(stall3), .wbserr_o(err3)
  );

  task automatic bus(input logic cyc, input logic stb, input logic we,
                     input logic [63:0] adr, input logic [15:0] dat, input logic [1:0] sel);
    @(negedge clk_i);
    s_dat1 = dat1; s_ack1 = ack1; s_err1 = err1;
    s_dat3 = dat3; s_ack3 = ack3; s_err3 = err3;
    wbscyc_i = cyc; wbsstb_i = stb; wbswe_i = we;
    wbsadr_i = adr; wbsdat_i = dat; wbssel_i = sel;
  endtask

  task automatic idle();
    bus(1'b1, 1'b0, 1'b0, 64'h0, 16'h0, 2'b00);
  endtask

  task automatic test_reset();
    bus(1'b1, 1'b1, 1'b0, 64'h0, 16'h0, 2'b11);
    @(posedge clk_i);
    #1;
    reset_ni = 1'b0;
    #1;
    total++;
    if (ack1 !== 1'b0 || ack3 !== 1'b0) begin
      bad++; $display("FAIL reset_ack_async got=%b%b exp=00", ack1, ack3);
    end
    total++;
    if (dat1 !== 16'h0 || err1 !== 1'b0 || stall1 !== 1'b0 || stall3 !== 1'b0) begin
      bad++; $display("FAIL reset_outputs dat=%h err=%b stall=%b%b exp=0", dat1, err1, stall1, stall3);
    end
    idle();
    @(negedge clk_i);
    reset_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      total++;
      if (s_ack1 !== 1'b0 || s_ack3 !== 1'b0) begin
        bad++; $display("FAIL reset_hold_ack%0d got=%b%b exp=00", i, s_ack1, s_ack3);
      end
    end
  endtask

  task automatic test_halfword();
    bus(1'b1, 1'b1, 1'b1, 64'h10, 16'hBEEF, 2'b11);
    bus(1'b1, 1'b1, 1'b0, 64'h10, 16'h0, 2'b11);
    total++;
    if (s_ack1 !== 1'b1 || s_dat1 !== 16'h0) begin
      bad++; $display("FAIL hw_write_ack ack=%b dat=%h exp ack=1 dat=0000", s_ack1, s_dat1);
    end
    idle();
    total++;
    if (s_ack1 !== 1'b1 || s_dat1 !== 16'hBEEF) begin
      bad++; $display("FAIL hw_read ack=%b dat=%h exp ack=1 dat=beef", s_ack1, s_dat1);
    end
    idle();
    total++;
    if (s_ack1 !== 1'b0) begin
      bad++; $display("FAIL hw_ack_end got=%b exp=0", s_ack1);
    end
  endtask

  task automatic test_byte_lanes();
    bus(1'b1, 1'b1, 1'b1, 64'h20, 16'h1234, 2'b11);
    bus(1'b1, 1'b1, 1'b1, 64'h21, 16'hAA55, 2'b10);
    bus(1'b1, 1'b1, 1'b1, 64'h20, 16'hCC77, 2'b01);
    bus(1'b1, 1'b1, 1'b0, 64'h20, 16'h0, 2'b01);
    idle();
    total++;
    if (s_ack1 !== 1'b1 || s_dat1 !== 16'hAA77) begin
      bad++; $display("FAIL byte_lanes ack=%b dat=%h exp ack=1 dat=aa77", s_ack1, s_dat1);
    end
    // sel=00 write changes nothing but is acked
    bus(1'b1, 1'b1, 1'b1, 64'h20, 16'hFFFF, 2'b00);
    bus(1'b1, 1'b1, 1'b0, 64'h20, 16'h0, 2'b11);
    total++;
    if (s_ack1 !== 1'b1) begin
      bad++; $display("FAIL sel00_ack got=%b exp=1", s_ack1);
    end
    idle();
    total++;
    if (s_dat1 !== 16'hAA77) begin
      bad++; $display("FAIL sel00_nowrite got=%h exp=aa77", s_dat1);
    end
    // strobe without cyc: no ack, no write
    bus(1'b0, 1'b1, 1'b1, 64'h20, 16'hFFFF, 2'b11);
    idle();
    total++;
    if (s_ack1 !== 1'b0) begin
      bad++; $display("FAIL stb_nocyc_ack got=%b exp=0", s_ack1);
    end
    bus(1'b1, 1'b1, 1'b0, 64'h20, 16'h0, 2'b11);
    idle();
    total++;
    if (s_dat1 !== 16'hAA77) begin
      bad++; $display("FAIL stb_nocyc_nowrite got=%h exp=aa77", s_dat1);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [4];
    logic        exp_a [8];
    exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;
    exp_a[0] = 1'b0; exp_a[1] = 1'b0; exp_a[2] = 1'b1; exp_a[3] = 1'b1;
    exp_a[4] = 1'b1; exp_a[5] = 1'b1; exp_a[6] = 1'b0; exp_a[7] = 1'b0;
    bus(1'b1, 1'b1, 1'b1, 64'h40, 16'h1111, 2'b11);
    bus(1'b1, 1'b1, 1'b1, 64'h42, 16'h2222, 2'b11);
    bus(1'b1, 1'b1, 1'b1, 64'h44, 16'h3333, 2'b11);
    bus(1'b1, 1'b1, 1'b1, 64'h46, 16'h4444, 2'b11);
    for (int i = 0; i < 4; i++) idle();
    // four reads, one per clock; sample k reflects the state after accept edge k+1
    for (int i = 0; i < 8; i++) begin
      if (i < 4) bus(1'b1, 1'b1, 1'b0, 64'h40 + 64'(2 * i), 16'h0, 2'b11);
      else idle();
      if (i >= 1) begin
        total++;
        if (s_ack3 !== exp_a[i-1]) begin
          bad++; $display("FAIL burst_ack%0d got=%b exp=%b", i - 1, s_ack3, exp_a[i-1]);
        end
        if (exp_a[i-1]) begin
          total++;
          if (s_dat3 !== exp_d[i-3]) begin
            bad++; $display("FAIL burst_dat%0d got=%h exp=%h", i - 3, s_dat3, exp_d[i-3]);
          end
        end
      end
    end
  endtask

  task automatic test_abort();
    bus(1'b1, 1'b1, 1'b0, 64'h40, 16'h0, 2'b11);
    bus(1'b1, 1'b1, 1'b0, 64'h42, 16'h0, 2'b11);
    bus(1'b0, 1'b0, 1'b0, 64'h0, 16'h0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      idle();
      total++;
      if (s_ack3 !== 1'b0) begin
        bad++; $display("FAIL abort_noack%0d got=%b exp=0", i, s_ack3);
      end
    end
    bus(1'b1, 1'b1, 1'b0, 64'h44, 16'h0, 2'b11);
    for (int i = 0; i < 4; i++) begin
      idle();
      total++;
      if (s_ack3 !== (i == 2)) begin
        bad++; $display("FAIL abort_after_ack%0d got=%b exp=%b", i, s_ack3, (i == 2));
      end
    end
    // the 3rd-cycle ack must carry the preloaded data
    bus(1'b1, 1'b1, 1'b0, 64'h44, 16'h0, 2'b11);
    idle(); idle(); idle();
    total++;
    if (s_ack3 !== 1'b1 || s_dat3 !== 16'h3333) begin
      bad++; $display("FAIL abort_after_dat ack=%b dat=%h exp ack=1 dat=3333", s_ack3, s_dat3);
    end
  endtask

  task automatic test_range();
    bus(1'b1, 1'b1, 1'b1, 64'h000, 16'h1357, 2'b11);
    bus(1'b1, 1'b1, 1'b1, 64'h800, 16'h5A5A, 2'b11);
    bus(1'b1, 1'b1, 1'b0, 64'h000, 16'h0, 2'b11);
`ifdef WBS_ERR_EN
    total++;
    if (s_err1 !== 1'b1 || s_ack1 !== 1'b0 || s_dat1 !== 16'h0) begin
      bad++; $display("FAIL oor_err err=%b ack=%b dat=%h exp err=1 ack=0 dat=0000", s_err1, s_ack1, s_dat1);
    end
    idle();
    total++;
    if (s_ack1 !== 1'b1 || s_err1 !== 1'b0 || s_dat1 !== 16'h1357) begin
      bad++; $display("FAIL oor_read ack=%b err=%b dat=%h exp ack=1 err=0 dat=1357", s_ack1, s_err1, s_dat1);
    end
`else
    total++;
    if (s_err1 !== 1'b0 || s_ack1 !== 1'b1) begin
      bad++; $display("FAIL alias_write err=%b ack=%b exp err=0 ack=1", s_err1, s_ack1);
    end
    idle();
    total++;
    if (s_ack1 !== 1'b1 || s_dat1 !== 16'h5A5A) begin
      bad++; $display("FAIL alias_read ack=%b dat=%h exp ack=1 dat=5a5a", s_ack1, s_dat1);
    end
`endif
    idle();
    total++;
    if (s_err3 !== 1'b0 && s_ack3 !== 1'b0) begin
      bad++; $display("FAIL range_l3_excl err=%b ack=%b exp not both", s_err3, s_ack3);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    test_reset();
    test_halfword();
    test_byte_lanes();
    test_back_to_back();
    test_abort();
    test_range();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
